// File: rtl/res_station_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : res_station_bank_if
// Description : Issue, common-data-bus, dispatch and status signals of the
//               reservation-station bank, grouped for module connection.
//               master = issuing / broadcasting / executing side,
//               slave  = the reservation-station bank itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface res_station_bank_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int NUM_RS = 4
);
  // issue port
  logic              Issue_valid;
  logic              Issue_ready;
  logic [2:0]        Issue_op;
  logic [DATA_W-1:0] Issue_vj;
  logic [DATA_W-1:0] Issue_vk;
  logic [TAG_W-1:0]  Issue_qj;
  logic [TAG_W-1:0]  Issue_qk;
  logic [TAG_W-1:0]  Issue_tag;
  // common data bus
  logic              CDB_valid;
  logic [TAG_W-1:0]  CDB_tag;
  logic [DATA_W-1:0] CDB_data;
  // dispatch to functional unit
  logic              Exec_valid;
  logic              Exec_ready;
  logic [2:0]        Exec_op;
  logic [DATA_W-1:0] Exec_a;
  logic [DATA_W-1:0] Exec_b;
  logic [TAG_W-1:0]  Exec_tag;
  // status
  logic [NUM_RS-1:0] Busy;

  modport master (
    output Issue_valid, Issue_op, Issue_vj, Issue_vk, Issue_qj, Issue_qk,
    input  Issue_ready, Issue_tag,
    output CDB_valid, CDB_tag, CDB_data,
    input  Exec_valid, Exec_op, Exec_a, Exec_b, Exec_tag,
    output Exec_ready,
    input  Busy
  );

  modport slave (
    input  Issue_valid, Issue_op, Issue_vj, Issue_vk, Issue_qj, Issue_qk,
    output Issue_ready, Issue_tag,
    input  CDB_valid, CDB_tag, CDB_data,
    output Exec_valid, Exec_op, Exec_a, Exec_b, Exec_tag,
    input  Exec_ready,
    output Busy
  );
endinterface
`default_nettype wire

// File: rtl/res_station_bank.sv
`default_nettype none
// ============================================================================
// Module      : res_station_bank
// Description : Bank of NUM_RS reservation stations. Entries are issued into
//               the lowest free slot, wake up by snooping the CDB, and are
//               dispatched round-robin to one functional unit. Entry i owns
//               tag TAG_BASE+i and is freed when that tag is broadcast.
//               Optional feature macro: RS_FLUSH_EN adds a Flush input that
//               frees every entry at the next rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module res_station_bank #(
  parameter int NUM_RS   = 4,
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 3,
  parameter int TAG_BASE = 1
) (
  input  logic Clock,
  input  logic Reset,
`ifdef RS_FLUSH_EN
  input  logic Flush,
`endif
  res_station_bank_if.slave bus
);

  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_EXEC  = 2'd3
  } rs_state_t;

  rs_state_t         state     [NUM_RS];
  rs_state_t         state_nxt [NUM_RS];
  logic [2:0]        op        [NUM_RS];
  logic [2:0]        op_nxt    [NUM_RS];
  logic [DATA_W-1:0] vj        [NUM_RS];
  logic [DATA_W-1:0] vj_nxt    [NUM_RS];
  logic [DATA_W-1:0] vk        [NUM_RS];
  logic [DATA_W-1:0] vk_nxt    [NUM_RS];
  logic [TAG_W-1:0]  qj        [NUM_RS];
  logic [TAG_W-1:0]  qj_nxt    [NUM_RS];
  logic [TAG_W-1:0]  qk        [NUM_RS];
  logic [TAG_W-1:0]  qk_nxt    [NUM_RS];

  logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic              lock, lock_nxt;
  logic [IDX_W-1:0]  lock_idx, lock_idx_nxt;

  logic              any_free;
  logic [IDX_W-1:0]  free_idx;
  logic              rr_found;
  logic [IDX_W-1:0]  rr_idx;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  sel;
  logic              issue_ready;
  logic              issue_fire;
  logic              exec_valid;
  logic              dispatch;
  logic              byp_j, byp_k;
  logic [TAG_W-1:0]  eff_qj, eff_qk;
  logic [NUM_RS-1:0] busy;

  // Lowest-index free entry is the issue target.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (state[i] == S_FREE) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Round-robin search over READY entries, starting just after the last dispatched index.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int off = 1; off <= NUM_RS; off++) begin
      cand = IDX_W'((int'(rr_ptr) + off) % NUM_RS);
      if (!rr_found && state[cand] == S_READY) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // A stalled offer stays locked so the functional unit sees stable operands.
  assign sel         = lock ? lock_idx : rr_idx;
  assign exec_valid  = !Reset && (lock || rr_found);
  assign dispatch    = exec_valid && bus.Exec_ready;
  assign issue_ready = !Reset && any_free;
  assign issue_fire  = bus.Issue_valid && issue_ready;

  // Same-cycle CDB bypass for operands being issued.
  assign byp_j  = bus.CDB_valid && (bus.Issue_qj != '0) && (bus.Issue_qj == bus.CDB_tag);
  assign byp_k  = bus.CDB_valid && (bus.Issue_qk != '0) && (bus.Issue_qk == bus.CDB_tag);
  assign eff_qj = byp_j ? '0 : bus.Issue_qj;
  assign eff_qk = byp_k ? '0 : bus.Issue_qk;

  // Per-entry next state: CDB snoop/free, then issue, dispatch and flush.
  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      state_nxt[i] = state[i];
      op_nxt[i]    = op[i];
      vj_nxt[i]    = vj[i];
      vk_nxt[i]    = vk[i];
      qj_nxt[i]    = qj[i];
      qk_nxt[i]    = qk[i];
    end
    rr_ptr_nxt   = rr_ptr;
    lock_nxt     = lock;
    lock_idx_nxt = lock_idx;

    for (int i = 0; i < NUM_RS; i++) begin
      case (state[i])
        S_WAIT: begin
          if (bus.CDB_valid && (bus.CDB_tag != '0) && (qj[i] == bus.CDB_tag)) begin
            vj_nxt[i] = bus.CDB_data;
            qj_nxt[i] = '0;
          end
          if (bus.CDB_valid && (bus.CDB_tag != '0) && (qk[i] == bus.CDB_tag)) begin
            vk_nxt[i] = bus.CDB_data;
            qk_nxt[i] = '0;
          end
          if ((qj_nxt[i] == '0) && (qk_nxt[i] == '0))
            state_nxt[i] = S_READY;
        end
        S_EXEC: begin
          if (bus.CDB_valid && (bus.CDB_tag == TAG_W'(TAG_BASE + i)))
            state_nxt[i] = S_FREE;
        end
        default: ;
      endcase
    end

    if (issue_fire) begin
      op_nxt[free_idx]    = bus.Issue_op;
      vj_nxt[free_idx]    = byp_j ? bus.CDB_data : bus.Issue_vj;
      vk_nxt[free_idx]    = byp_k ? bus.CDB_data : bus.Issue_vk;
      qj_nxt[free_idx]    = eff_qj;
      qk_nxt[free_idx]    = eff_qk;
      state_nxt[free_idx] = ((eff_qj == '0) && (eff_qk == '0)) ? S_READY : S_WAIT;
    end

    if (dispatch) begin
      state_nxt[sel] = S_EXEC;
      rr_ptr_nxt     = sel;
      lock_nxt       = 1'b0;
    end else if (exec_valid) begin
      lock_nxt     = 1'b1;
      lock_idx_nxt = sel;
    end

`ifdef RS_FLUSH_EN
    if (Flush) begin
      for (int i = 0; i < NUM_RS; i++)
        state_nxt[i] = S_FREE;
      lock_nxt = 1'b0;
    end
`endif
  end

  // State register; reset discards every in-flight entry immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_RS; i++) begin
        state[i] <= S_FREE;
        op[i]    <= '0;
        vj[i]    <= '0;
        vk[i]    <= '0;
        qj[i]    <= '0;
        qk[i]    <= '0;
      end
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        state[i] <= state_nxt[i];
        op[i]    <= op_nxt[i];
        vj[i]    <= vj_nxt[i];
        vk[i]    <= vk_nxt[i];
        qj[i]    <= qj_nxt[i];
        qk[i]    <= qk_nxt[i];
      end
      rr_ptr   <= rr_ptr_nxt;
      lock     <= lock_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  // Busy flags: any entry not FREE.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_RS; i++)
      busy[i] = (state[i] != S_FREE);
  end

  assign bus.Issue_ready = issue_ready;
  assign bus.Issue_tag   = issue_ready ? (TAG_W'(TAG_BASE) + TAG_W'(free_idx)) : '0;
  assign bus.Exec_valid  = exec_valid;
  assign bus.Exec_op     = exec_valid ? op[sel] : '0;
  assign bus.Exec_a      = exec_valid ? vj[sel] : '0;
  assign bus.Exec_b      = exec_valid ? vk[sel] : '0;
  assign bus.Exec_tag    = exec_valid ? (TAG_W'(TAG_BASE) + TAG_W'(sel)) : '0;
  assign bus.Busy        = busy;

endmodule
`default_nettype wire
